// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared constants and FSM encoding for the AXI4-Lite write master.
package axi4_lite_pkg;

  // BRESP encodings
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] AWPROT_DEFAULT = 3'b000;

  // One-hot write sequencer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SEND   = 4'b0010,
    ST_WAIT_B = 4'b0100,
    ST_RESP   = 4'b1000
  } wr_state_e;

endpackage

// File: rtl/axi4_lite_hs_reg.sv
// axi4_lite_hs_reg: valid-hold / done-flag cell for one AXI request channel.
// valid rises on load, stays high until the handshake, then done is recorded.
module axi4_lite_hs_reg (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic ready,
  output logic valid,
  output logic done,
  output logic fire
);

  logic valid_r;
  logic done_r;

  assign valid = valid_r;
  assign done  = done_r;
  // Handshake completing this cycle; feeds the sequencer's next-state decision only
  assign fire  = valid_r & ready;

  // Hold valid until accepted, then flag completion until the next load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      done_r  <= 1'b0;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      done_r  <= 1'b1;
    end else begin
      valid_r <= valid_r;
      done_r  <= done_r;
    end
  end

endmodule

// File: rtl/axi4_lite_wr_master.sv
// axi4_lite_wr_master: single-beat AXI4-Lite write master with a user
// request channel and a valid/ready response channel.
// Optional watchdog: define WR_TIMEOUT_EN to add the wr_timeout output.
module axi4_lite_wr_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  localparam int STRB_W     = DATA_W / 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [1:0]        wr_resp,
  output logic              wr_resp_valid,
  input  logic              wr_resp_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
`ifdef WR_TIMEOUT_EN
  ,
  output logic              wr_timeout
`endif
);

  wr_state_e         state_r;
  logic              wr_ready_r;
  logic              busy_r;
  logic              bready_r;
  logic              resp_valid_r;
  logic [1:0]        resp_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [STRB_W-1:0] wstrb_r;

  logic accept_s;
  logic aw_valid_s, aw_done_s, aw_fire_s, aw_fin_s;
  logic w_valid_s, w_done_s, w_fire_s, w_fin_s;

  assign accept_s = (state_r == ST_IDLE) & wr_valid & wr_ready_r;
  // A channel counts as finished in the cycle its handshake completes
  assign aw_fin_s = aw_done_s | aw_fire_s;
  assign w_fin_s  = w_done_s | w_fire_s;

  axi4_lite_hs_reg u_aw_hs (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .ready (m_axi_awready),
    .valid (aw_valid_s),
    .done  (aw_done_s),
    .fire  (aw_fire_s)
  );

  axi4_lite_hs_reg u_w_hs (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .ready (m_axi_wready),
    .valid (w_valid_s),
    .done  (w_done_s),
    .fire  (w_fire_s)
  );

  // Write sequencer: accept, issue AW/W, collect B, hand BRESP back to the user
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      wr_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      bready_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_r       <= BRESP_OKAY;
      awaddr_r     <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      wstrb_r      <= {STRB_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_valid && wr_ready_r) begin
            awaddr_r   <= wr_addr;
            wdata_r    <= wr_data;
            wstrb_r    <= wr_strb;
            wr_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (aw_fin_s && w_fin_s) begin
            bready_r <= 1'b1;
            state_r  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (m_axi_bvalid) begin
            resp_r       <= m_axi_bresp;
            bready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            state_r      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // No new request in this cycle; wr_ready returns on the next one
          if (wr_resp_ready) begin
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            wr_ready_r   <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          wr_ready_r   <= 1'b1;
          busy_r       <= 1'b0;
          bready_r     <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready      = wr_ready_r;
  assign wr_resp       = resp_r;
  assign wr_resp_valid = resp_valid_r;
  assign busy          = busy_r;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awprot  = AWPROT_DEFAULT;
  assign m_axi_awvalid = aw_valid_s;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = w_valid_s;
  assign m_axi_bready  = bready_r;

`ifdef WR_TIMEOUT_EN
  localparam int               TO_CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);
  localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] to_cnt_r;
  logic                to_flag_r;

  // Watchdog: count cycles spent waiting on the slave; flag is sticky until next request
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r  <= {TO_CNT_W{1'b0}};
      to_flag_r <= 1'b0;
    end else if (accept_s) begin
      to_cnt_r  <= {TO_CNT_W{1'b0}};
      to_flag_r <= 1'b0;
    end else if (((state_r == ST_SEND) || (state_r == ST_WAIT_B)) && (to_cnt_r != TO_LIMIT)) begin
      to_cnt_r  <= to_cnt_r + TO_CNT_W'(1);
      to_flag_r <= to_flag_r | (to_cnt_r == TO_LAST);
    end else begin
      to_cnt_r  <= to_cnt_r;
      to_flag_r <= to_flag_r;
    end
  end

  assign wr_timeout = to_flag_r;
`endif

endmodule

// File: tb/tb_axi4_lite_wr_master.sv
// tb_axi4_lite_wr_master: directed scoreboard bench for the AXI4-Lite write master.
// Stimulus pushes expected AW/W/B values into queues; a negedge monitor pops and compares.
module tb_axi4_lite_wr_master;

  logic        clk;
  logic        rst;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_resp;
  logic        wr_resp_valid;
  logic        wr_resp_ready;
  logic        busy;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
`ifdef WR_TIMEOUT_EN
  logic        wr_timeout;
`endif

  axi4_lite_wr_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_resp       (wr_resp),
    .wr_resp_valid (wr_resp_valid),
    .wr_resp_ready (wr_resp_ready),
    .busy          (busy),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
`ifdef WR_TIMEOUT_EN
    ,
    .wr_timeout    (wr_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave / user-side timing knobs (cycles of wait before ready/valid)
  int aw_dly = 0;
  int w_dly  = 0;
  int b_dly  = 0;
  int rr_dly = 0;

  // Scoreboard queues
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_strb[$];
  logic [1:0]  exp_resp[$];
  logic [1:0]  sl_bresp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave + response consumer model ----------------
  initial begin
    bit aw_f, w_f, b_f, r_f, rst_smp, aw_ok, w_ok;
    int aw_seen, w_seen, b_seen, rr_seen;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; wr_resp_ready = 1'b0;
    aw_ok = 1'b0; w_ok = 1'b0; aw_seen = 0; w_seen = 0; b_seen = 0; rr_seen = 0;
    forever begin
      @(negedge clk);
      aw_f = m_axi_awvalid & m_axi_awready;
      w_f  = m_axi_wvalid & m_axi_wready;
      b_f  = m_axi_bvalid & m_axi_bready;
      r_f  = wr_resp_valid & wr_resp_ready;
      rst_smp = rst;
      @(posedge clk); #1;
      if (rst_smp) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; wr_resp_ready = 1'b0;
        aw_ok = 1'b0; w_ok = 1'b0; aw_seen = 0; w_seen = 0; b_seen = 0; rr_seen = 0;
      end else begin
        if (aw_f) begin m_axi_awready = 1'b0; aw_seen = 0; aw_ok = 1'b1; end
        else if (m_axi_awvalid && !m_axi_awready) begin aw_seen++; m_axi_awready = (aw_seen > aw_dly); end
        if (w_f) begin m_axi_wready = 1'b0; w_seen = 0; w_ok = 1'b1; end
        else if (m_axi_wvalid && !m_axi_wready) begin w_seen++; m_axi_wready = (w_seen > w_dly); end
        if (b_f) begin m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; end
        if (aw_ok && w_ok && !m_axi_bvalid) begin
          b_seen++;
          if (b_seen > b_dly) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp = (sl_bresp.size() != 0) ? sl_bresp.pop_front() : 2'b00;
            aw_ok = 1'b0; w_ok = 1'b0; b_seen = 0;
          end
        end
        if (r_f) begin wr_resp_ready = 1'b0; rr_seen = 0; end
        else if (wr_resp_valid && !wr_resp_ready) begin rr_seen++; wr_resp_ready = (rr_seen > rr_dly); end
      end
    end
  end

  // ---------------- monitor / scoreboard checker ----------------
  int n_acc = 0, n_done = 0, t_fire = 0, t_b = 0, aw_hi = 0, w_hi = 0;
  bit aw_hs = 1'b0, w_hs = 1'b0, b_chk = 1'b0, rv_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      n_acc = 0; n_done = 0; aw_hi = 0; w_hi = 0;
      aw_hs = 1'b0; w_hs = 1'b0; b_chk = 1'b0; rv_seen = 1'b0;
    end else begin
      chk("busy", busy, (n_acc != n_done));
      if (wr_valid && wr_ready) begin
        chk("one_outstanding", n_acc, n_done);
        n_acc++;
        aw_hi = 0; w_hi = 0; aw_hs = 1'b0; w_hs = 1'b0; b_chk = 1'b0; rv_seen = 1'b0;
      end
      if (m_axi_bready && !b_chk) begin
        b_chk = 1'b1;
        chk("bready_after_aw_w", (aw_hs && w_hs), 1'b1);
      end
      if (m_axi_awvalid) begin
        aw_hi++;
        if (exp_addr.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
        else chk("awaddr", m_axi_awaddr, exp_addr[0]);
        if (m_axi_awready) begin
          chk("aw_valid_cycles", aw_hi, aw_dly + 1);
          chk("awprot", m_axi_awprot, 3'b000);
          if (exp_addr.size() != 0) void'(exp_addr.pop_front());
          aw_hs = 1'b1; t_fire = cyc;
        end
      end
      if (m_axi_wvalid) begin
        w_hi++;
        if (exp_data.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
        else begin
          chk("wdata", m_axi_wdata, exp_data[0]);
          chk("wstrb", m_axi_wstrb, exp_strb[0]);
        end
        if (m_axi_wready) begin
          chk("w_valid_cycles", w_hi, w_dly + 1);
          if (exp_data.size() != 0) begin void'(exp_data.pop_front()); void'(exp_strb.pop_front()); end
          w_hs = 1'b1; t_fire = cyc;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        chk("b_cycle", cyc, t_fire + 1 + b_dly);
        t_b = cyc;
      end
      if (wr_resp_valid) begin
        if (!rv_seen) begin rv_seen = 1'b1; chk("resp_latency", cyc, t_b + 1); end
        chk("wr_ready_low_in_resp", wr_ready, 1'b0);
        if (exp_resp.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
        else chk("wr_resp", wr_resp, exp_resp[0]);
        if (wr_resp_ready) begin
          if (exp_resp.size() != 0) void'(exp_resp.pop_front());
          n_done++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                        input logic [1:0] br, input bit keep);
    int waited;
    @(posedge clk); #1;
    exp_addr.push_back(a); exp_data.push_back(d); exp_strb.push_back(s);
    exp_resp.push_back(br); sl_bresp.push_back(br);
    wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      waited++;
      if (waited > 300) begin chk("accept_timeout", waited, 0); break; end
    end
    @(posedge clk); #1;
    if (!keep) begin
      wr_valid = 1'b0; wr_addr = ~a; wr_data = ~d; wr_strb = ~s;
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (exp_resp.size() == 0 && !busy) break;
      waited++;
      if (waited > 300) begin chk("idle_timeout", waited, 0); break; end
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = 32'h0; wr_data = 64'h0; wr_strb = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_resp_valid", wr_resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_awaddr", m_axi_awaddr, 32'h0);
    chk("rst_wdata", m_axi_wdata, 64'h0);
    chk("rst_wstrb", m_axi_wstrb, 8'h0);
    chk("rst_wr_resp", wr_resp, 2'b00);

    // Zero-wait slave
    do_req(32'h0000_0010, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'b00, 1'b0);
    wait_idle();

    // AW delayed 5 cycles, W immediate
    aw_dly = 5;
    do_req(32'h0000_0020, 64'h0000_0000_CAFE_F00D, 8'h03, 2'b01, 1'b0);
    wait_idle();
    aw_dly = 0;

    // SLVERR with response consumer stalling 3 cycles
    rr_dly = 3;
    do_req(32'h0000_0030, 64'h0000_0000_1234_5678, 8'hFF, 2'b10, 1'b0);
    wait_idle();
    rr_dly = 0;

    // Back-to-back with wr_valid held high
    do_req(32'h0000_0004, 64'h0000_0000_AAAA_0004, 8'h0F, 2'b00, 1'b1);
    do_req(32'h0000_0008, 64'h0000_0000_BBBB_0008, 8'h0F, 2'b00, 1'b0);
    wait_idle();

    // Full 64-bit data with partial strobes
    do_req(32'h0000_0040, 64'h1122_3344_5566_7788, 8'h0F, 2'b00, 1'b0);
    wait_idle();

    // Zero strobes, W delayed, DECERR
    w_dly = 3;
    do_req(32'h0000_0044, 64'hFFFF_0000_FFFF_0000, 8'h00, 2'b11, 1'b0);
    wait_idle();
    w_dly = 0;

    // Reset while AW is still pending
    aw_dly = 50;
    do_req(32'h0000_0050, 64'h0000_0000_5555_AAAA, 8'hF0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_addr.delete(); exp_data.delete(); exp_strb.delete(); exp_resp.delete(); sl_bresp.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    aw_dly = 0;
    @(negedge clk);
    chk("midrst_awvalid", m_axi_awvalid, 1'b0);
    chk("midrst_wvalid", m_axi_wvalid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_wr_ready", wr_ready, 1'b1);
    chk("midrst_resp_valid", wr_resp_valid, 1'b0);
    do_req(32'h0000_0060, 64'h0000_0000_0000_0060, 8'h01, 2'b00, 1'b0);
    wait_idle();

`ifdef WR_TIMEOUT_EN
    // Watchdog: B withheld 20 cycles, limit 16
    b_dly = 20;
    do_req(32'h0000_0070, 64'h0000_0000_0000_0070, 8'h0F, 2'b00, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("timeout_before_limit", wr_timeout, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("timeout_at_limit", wr_timeout, 1'b1);
    wait_idle();
    chk("timeout_sticky", wr_timeout, 1'b1);
    b_dly = 0;
    do_req(32'h0000_0074, 64'h0000_0000_0000_0074, 8'h0F, 2'b00, 1'b0);
    @(negedge clk);
    chk("timeout_cleared", wr_timeout, 1'b0);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
